// File: rtl/seq_det_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_det_pkg : shared state encoding and limits for seq_detector_param
// Revision    : 1.0
// ---------------------------------------------------------------------------
package seq_det_pkg;

  localparam int PAT_W_MAX = 32;

  typedef enum logic [1:0] {
    UNARMED = 2'b00,
    HUNT    = 2'b01,
    MATCH   = 2'b10
  } state_t;

  // 2'b11 is not a legal encoding and is treated as UNARMED.
  function automatic logic state_is_armed(input state_t s);
    return (s == HUNT) || (s == MATCH);
  endfunction

endpackage : seq_det_pkg
`default_nettype wire

// File: rtl/seq_det_history.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_det_history : serial history shift register, fill counter and compare
// Revision        : 1.0
// ---------------------------------------------------------------------------
module seq_det_history
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 4
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             shift_en,
  input  logic             clear,
  input  logic             overlap,
  input  logic             din,
  input  logic [PAT_W-1:0] pat,
  output logic             match
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  hist_q, hist_d, hist_shift;
  logic [FILL_W-1:0] fill_q, fill_d, fill_inc;

  // Match is judged on the values the history would hold after this shift.
  always_comb begin
    hist_shift = {hist_q[PAT_W-2:0], din};
    fill_inc   = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
    match      = shift_en && !clear && (fill_inc == FILL_FULL) && (hist_shift == pat);
    hist_d     = hist_q;
    fill_d     = fill_q;
    if (clear) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift_en) begin
      if (match && !overlap) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = hist_shift;
        fill_d = fill_inc;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule : seq_det_history
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_detector_param : Moore serial-pattern detector with runtime pattern and
//                      overlap mode; match counter built when MATCH_COUNT_EN
//                      is defined.
// Revision           : 1.0
// ---------------------------------------------------------------------------
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Din,
  input  logic             Din_valid,
  input  logic             Load,
  input  logic [PAT_W-1:0] Pattern,
  input  logic             Overlap,
  output logic             Dout,
  output logic             Armed,
  output logic [CNT_W-1:0] Match_count
);

  if (PAT_W < 2 || PAT_W > PAT_W_MAX) begin : g_pat_w_check
    $error("seq_detector_param: PAT_W=%0d outside 2..%0d", PAT_W, PAT_W_MAX);
  end

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("seq_detector_param: CNT_W must be at least 1");
  end

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             shift_en;
  logic             hit;

  assign shift_en = state_is_armed(state_q) && Din_valid && !Load;

  seq_det_history #(
    .PAT_W (PAT_W)
  ) u_history (
    .Clock    (Clock),
    .Reset    (Reset),
    .shift_en (shift_en),
    .clear    (Load),
    .overlap  (Overlap),
    .din      (Din),
    .pat      (pat_q),
    .match    (hit)
  );

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    if (Load) begin
      pat_d   = Pattern;
      state_d = HUNT;
    end else begin
      case (state_q)
        HUNT, MATCH: state_d = (shift_en && hit) ? MATCH : HUNT;
        default:     state_d = UNARMED;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= UNARMED;
      pat_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
    end
  end

  assign Dout  = (state_q == MATCH);
  assign Armed = state_is_armed(state_q);

`ifdef MATCH_COUNT_EN
  logic [CNT_W-1:0] count_q, count_d;

  // Saturating count of edges that enter or re-enter MATCH.
  always_comb begin
    count_d = count_q;
    if (Load) begin
      count_d = '0;
    end else if (hit && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign Match_count = count_q;
`else
  assign Match_count = '0;
`endif

endmodule : seq_detector_param
`default_nettype wire

// File: tb/tb_seq_detector_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_seq_detector_param : directed self-checking bench for seq_detector_param
// Revision              : 1.0
// ---------------------------------------------------------------------------
module tb_seq_detector_param;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Din = 1'b0;
  logic       Din_valid = 1'b0;
  logic       Load = 1'b0;
  logic       Overlap = 1'b1;
  logic [2:0] pattern3 = 3'b000;
  logic [3:0] pattern4 = 4'b0000;

  logic       dout3, armed3, dout4, armed4;
  logic [7:0] count3, count4;

  int errors = 0;
  int checks = 0;

  always #5 Clock = ~Clock;

  seq_detector_param #(.PAT_W(3), .CNT_W(8)) u_dut3 (
    .Clock       (Clock),
    .Reset       (Reset),
    .Din         (Din),
    .Din_valid   (Din_valid),
    .Load        (Load),
    .Pattern     (pattern3),
    .Overlap     (Overlap),
    .Dout        (dout3),
    .Armed       (armed3),
    .Match_count (count3)
  );

  seq_detector_param #(.PAT_W(4), .CNT_W(8)) u_dut4 (
    .Clock       (Clock),
    .Reset       (Reset),
    .Din         (Din),
    .Din_valid   (Din_valid),
    .Load        (Load),
    .Pattern     (pattern4),
    .Overlap     (Overlap),
    .Dout        (dout4),
    .Armed       (armed4),
    .Match_count (count4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Counter only exists in the MATCH_COUNT_EN build.
  function automatic logic [31:0] cnt_exp(input int n);
`ifdef MATCH_COUNT_EN
    return n;
`else
    return (n == 0) ? 0 : 0;
`endif
  endfunction

  // One clock: apply inputs, take the edge, settle 1 time unit after it.
  task automatic step(input logic d, input logic v, input logic ld);
    Din       = d;
    Din_valid = v;
    Load      = ld;
    @(posedge Clock);
    #1;
    Load      = 1'b0;
    Din_valid = 1'b0;
  endtask

  task automatic stream3(input string tag, input logic [4:0] bits, input logic [4:0] exp_dout,
                         input int n);
    for (int i = n - 1; i >= 0; i--) begin
      step(bits[i], 1'b1, 1'b0);
      check($sformatf("%s_dout_b%0d", tag, n - i), {31'd0, dout3}, {31'd0, exp_dout[i]});
    end
  endtask

  initial begin
    repeat (2) @(posedge Clock);
    #1;
    check("rst_dout", {31'd0, dout3}, 0);
    check("rst_armed", {31'd0, armed3}, 0);
    check("rst_count", {24'd0, count3}, 0);
    Reset = 1'b0;

    // No Load: bits ignored.
    step(1'b1, 1'b1, 1'b0);
    check("noload_dout1", {31'd0, dout3}, 0);
    check("noload_armed1", {31'd0, armed3}, 0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("noload_dout3", {31'd0, dout3}, 0);
    check("noload_armed3", {31'd0, armed3}, 0);

    // Overlapping 101.
    pattern3 = 3'b101; Overlap = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    check("ov_armed", {31'd0, armed3}, 1);
    check("ov_dout0", {31'd0, dout3}, 0);
    stream3("ov", 5'b10101, 5'b00101, 5);
    check("ov_count", {24'd0, count3}, cnt_exp(2));

    // Non-overlapping 101.
    Overlap = 1'b0;
    step(1'b0, 1'b0, 1'b1);
    check("nov_count_clr", {24'd0, count3}, 0);
    stream3("nov", 5'b10101, 5'b00100, 5);
    check("nov_count", {24'd0, count3}, cnt_exp(1));

    // PAT_W=4, 1111 with six ones: high after bits 4,5,6.
    pattern4 = 4'b1111; Overlap = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 1'b1, 1'b0);
      check($sformatf("p4_dout_b%0d", i), {31'd0, dout4}, (i >= 4) ? 1 : 0);
    end
    check("p4_count", {24'd0, count4}, cnt_exp(3));

    // Same, valid gap between bits 4 and 5.
    step(1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 1'b0);
    check("gap_dout_b4", {31'd0, dout4}, 1);
    step(1'b1, 1'b0, 1'b0);
    check("gap_dout_gap", {31'd0, dout4}, 0);
    step(1'b1, 1'b1, 1'b0);
    check("gap_dout_b5", {31'd0, dout4}, 1);

    // Mid-pattern Load: bit under Load discarded, count restarts.
    pattern3 = 3'b101; Overlap = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    pattern3 = 3'b110;
    step(1'b1, 1'b1, 1'b1);
    check("mid_dout_ld", {31'd0, dout3}, 0);
    check("mid_count_ld", {24'd0, count3}, 0);
    stream3("mid", 5'b00110, 5'b00001, 3);
    check("mid_count", {24'd0, count3}, cnt_exp(1));

    // Load with Din=1 then 1,0: a retained bit would make 110 here.
    step(1'b1, 1'b1, 1'b1);
    stream3("disc", 5'b00010, 5'b00000, 2);

    // Load during MATCH drops Dout.
    stream3("ldm", 5'b00110, 5'b00001, 3);
    step(1'b0, 1'b0, 1'b1);
    check("ldm_dout", {31'd0, dout3}, 0);
    check("ldm_armed", {31'd0, armed3}, 1);

    // Asynchronous reset during MATCH.
    pattern3 = 3'b101;
    step(1'b0, 1'b0, 1'b1);
    stream3("ar", 5'b00101, 5'b00001, 3);
    #2;
    Reset = 1'b1;
    #1;
    check("ar_dout", {31'd0, dout3}, 0);
    check("ar_armed", {31'd0, armed3}, 0);
    check("ar_count", {24'd0, count3}, 0);
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    stream3("ar_post", 5'b00101, 5'b00000, 3);
    check("ar_post_armed", {31'd0, armed3}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_seq_detector_param
`default_nettype wire

// File: doc/seq_detector_param.md
# seq_detector_param

Parameterised Moore serial-pattern detector. It samples a one-bit stream `Din`, qualified by `Din_valid`, and pulses `Dout` for one cycle each time the last `PAT_W` valid bits equal a runtime-loaded pattern. Overlapping and non-overlapping match modes are selectable at runtime, and an optional match counter can be compiled in. It sits in the serial-input datapath of the Ch-8 FSM lab designs. With `PAT_W=3`, `Pattern=3'b101` and `Overlap=1` it behaves as the classic overlapping 101 detector.

## Interface
- `PAT_W`, default 4: pattern length in bits; legal range 2..32; elaboration error outside that range.
- `CNT_W`, default 8: width of `Match_count`.
- `Clock` in 1: clock; all state updates on the rising edge.
- `Reset` in 1: reset, asynchronous, active-high.
- `Din` in 1: serial data bit.
- `Din_valid` in 1: `Din` is sampled only when this is 1.
- `Load` in 1: capture `Pattern` and clear the history.
- `Pattern` in `PAT_W`: pattern to detect; `Pattern[PAT_W-1]` is the first bit received, `Pattern[0]` the last.
- `Overlap` in 1: 1 = overlapping matches, 0 = non-overlapping.
- `Dout` out 1: match pulse; Moore output, decoded from the state register.
- `Armed` out 1: a pattern has been loaded since reset.
- `Match_count` out `CNT_W`: number of matches; only active when `MATCH_COUNT_EN` is defined.

## Operation
- Internal registers:
  - `pat[PAT_W-1:0]`: the loaded pattern.
  - `hist[PAT_W-1:0]`: shift history; newest bit enters at `hist[0]`.
  - `fill`: count of valid bits held, 0..`PAT_W`, saturating at `PAT_W`.
- States:
  - UNARMED: reset state; `Din` is ignored.
  - HUNT: collecting bits.
  - MATCH: `Dout`=1.
- Load (highest priority, any state): `pat<=Pattern`, `hist<=0`, `fill<=0`, go to HUNT. A `Din` bit presented in the same cycle is discarded.
- Bit accept, in HUNT or MATCH with `Din_valid=1` and `Load=0`:
  - `hist<={hist[PAT_W-2:0],Din}`, `fill<=min(fill+1,PAT_W)`.
  - A match is defined as: new `fill==PAT_W` and new `hist==pat`.
  - On a match, go to MATCH. Otherwise go to HUNT.
- Non-overlap mode (`Overlap=0` at the matching edge): on a match, `hist<=0` and `fill<=0` are written instead of the shifted values. The next match therefore requires `PAT_W` fresh bits.
- Overlap mode: history is retained, so a periodic pattern can produce back-to-back matches. Example: pattern 1111 with a stream of ones gives `Dout` continuously high.
- MATCH with `Din_valid=0`: go to HUNT; history is held.
- UNARMED: `Din`/`Din_valid` have no effect; `Dout=0`.
- `Overlap` is sampled every edge. A change takes effect at the next match decision; there is no retroactive clearing.
- `Armed = (state != UNARMED)`.

## Timing
- Reset values: state UNARMED, `Dout=0`, `Armed=0`, `Match_count=0`, `pat=0`, `hist=0`, `fill=0`.
- Match latency: `Dout` rises after the edge that samples the final pattern bit and stays high exactly one cycle per match. Consecutive matches keep it high.
- `Armed` rises after the first Load edge.
- Load during MATCH: `Dout` falls after that edge.
- `Reset` asserted mid-stream clears everything immediately, with no clock needed. After reset, a new Load is required before any detection.
- There is no combinational path from any input to `Dout` or `Armed`.

## Configuration
- `MATCH_COUNT_EN` defined:
  - `Match_count` increments by 1 on every edge that enters or re-enters MATCH.
  - It saturates at 2^`CNT_W`-1.
  - It is cleared by `Reset` and by `Load`.
- `MATCH_COUNT_EN` undefined: no counter logic is built; `Match_count` is tied to 0. The port list is identical in both builds.

## Structure
- Package `seq_det_pkg` holds:
  - state typedef: UNARMED=2'b00, HUNT=2'b01, MATCH=2'b10, with 2'b11 decoded as UNARMED;
  - `PAT_W_MAX=32`.
- Sub-module `seq_det_history`: shift register, fill counter and equality compare. Interface:
  - inputs: shift enable, clear, `Din`, `pat`;
  - output: match flag (combinational, evaluated on the next-history values).
- The top level holds `pat`, the FSM and the optional counter.

## Test plan
- Reset, then `Din_valid=1` with `Din` = 1,0,1 and no Load → `Dout`=0 and `Armed`=0 throughout.
- `PAT_W=3`, Load 3'b101, `Overlap=1`, stream 1,0,1,0,1 → `Dout` high after the 3rd and 5th bit edges; `Match_count=2`.
- Same stream with `Overlap=0` → `Dout` only after the 3rd bit; 5th bit gives no match; `Match_count=1`.
- `PAT_W=4`, Load 4'b1111, `Overlap=1`, six 1s → `Dout` high for 3 consecutive cycles (after bits 4, 5, 6); with `Din_valid` dropped between bits 4 and 5 → `Dout` low for that gap cycle.
- Mid-pattern Load: `PAT_W=3`, pattern 101, bits 1,0 then Load 3'b110 with `Din=1` → that bit is discarded; then 1,1,0 → single `Dout` pulse; `Match_count` restarted from 0.
- Assert `Reset` asynchronously during a MATCH cycle → `Dout`, `Armed` and `Match_count` go to 0 before the next edge; subsequent bits are ignored until Load.
